// File: rtl/toggle_hs_pkg.sv
// Shared types and constants for the two-phase toggle handshake blocks.
package toggle_hs_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } toggle_rx_state_t;

    localparam int TOGGLE_SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/toggle_sync.sv
// N-stage reset-to-0 bit synchronizer; shared by the request and acknowledge paths.
module toggle_sync
    import toggle_hs_pkg::*;
#(
    parameter int SYNC_STAGES = TOGGLE_SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_hs_rx.sv
// Receive side of the toggle-request handshake: sync the request, capture the word, hand it out on valid/ready.
// Optional sticky overrun detection is built when TOGGLE_HS_RX_OVERRUN_EN is defined.
module toggle_hs_rx
    import toggle_hs_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = TOGGLE_SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] req_data,
    output logic              ack_tgl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef TOGGLE_HS_RX_OVERRUN_EN
    ,
    output logic              overrun
`endif
);

    toggle_rx_state_t state, state_nxt;
    logic             req_s;
    logic             ack_nxt;
    logic             capture;

    toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
        .clk   (clk),
        .reset (reset),
        .d     (req_tgl),
        .q     (req_s)
    );

    always_comb begin
        state_nxt = state;
        ack_nxt   = ack_tgl;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (req_s != ack_tgl) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    ack_nxt   = ~ack_tgl;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // req_data is sampled unsynchronized; the sender keeps it stable until our ack flips.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ack_tgl  <= 1'b0;
            out_data <= '0;
        end else begin
            state   <= state_nxt;
            ack_tgl <= ack_nxt;
            if (capture) out_data <= req_data;
        end
    end

    assign out_valid = (state == HOLD);

`ifdef TOGGLE_HS_RX_OVERRUN_EN
    logic req_s_cap;

    // Any request movement while a word is held means the sender flipped before our ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_s_cap <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (capture) req_s_cap <= req_s;
            if (state == HOLD && req_s != req_s_cap) overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_toggle_hs_rx.sv
// Scoreboard bench for toggle_hs_rx: a sender model queues expected words, a monitor checks the output side.
module tb_toggle_hs_rx;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_tgl = 1'b0;
    logic [DATA_W-1:0] req_data = '0;
    logic              ack_tgl;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
`ifdef TOGGLE_HS_RX_OVERRUN_EN
    logic              overrun;
`endif

    toggle_hs_rx #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_tgl   (req_tgl),
        .req_data  (req_data),
        .ack_tgl   (ack_tgl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef TOGGLE_HS_RX_OVERRUN_EN
        ,
        .overrun   (overrun)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int                cmp_cnt = 0;
    int                err_cnt = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic              exp_ack = 1'b0;
    int                exp_rise = -1;
    logic              prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: words leave in send order, held while valid, one ack flip per acceptance.
    always @(negedge clk) begin
        if (!reset) begin
            prev_valid = 1'b0;
        end else begin
            chk("ack_tgl", {31'b0, ack_tgl}, {31'b0, exp_ack});
            if (out_valid && !prev_valid && exp_rise >= 0) begin
                chk("valid_latency", cyc, exp_rise);
                exp_rise = -1;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", {31'b0, out_valid}, 32'd0);
                end else begin
                    chk("out_data", {24'b0, out_data}, {24'b0, exp_q[0]});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        exp_ack = ~exp_ack;
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input bit timed);
        req_data = d;
        req_tgl  = ~req_tgl;
        exp_q.push_back(d);
        if (timed) exp_rise = cyc + 3;
    endtask

    task automatic wait_ack(input bit rnd_ready);
        for (int i = 0; i < 300; i++) begin
            if (ack_tgl == req_tgl) return;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            tick(1);
        end
        chk("ack_timeout", {31'b0, ack_tgl}, {31'b0, req_tgl});
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50; i++) begin
            if (out_valid) return;
            tick(1);
        end
        chk("valid_timeout", {31'b0, out_valid}, 32'd1);
    endtask

    initial begin
        // Reset state
        tick(3);
        chk("rst_ack", {31'b0, ack_tgl}, 32'd0);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_data", {24'b0, out_data}, 32'd0);
`ifdef TOGGLE_HS_RX_OVERRUN_EN
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
`endif
        reset = 1'b1;
        tick(2);

        // Single word, consumer always ready
        out_ready = 1'b1;
        send(8'hA5, 1'b1);
        wait_ack(1'b0);
        chk("single_ack", {31'b0, ack_tgl}, 32'd1);
        tick(2);

        // Back-pressure for 10 cycles
        out_ready = 1'b0;
        send(8'h3C, 1'b1);
        wait_valid();
        tick(10);
        chk("bp_valid_held", {31'b0, out_valid}, 32'd1);
        chk("bp_ack_held", {31'b0, ack_tgl}, 32'd1);
        out_ready = 1'b1;
        tick(1);
        chk("bp_done_valid", {31'b0, out_valid}, 32'd0);
        chk("bp_done_ack", {31'b0, ack_tgl}, 32'd0);

        // Four-word stream, sender flips only after seeing the ack
        for (int w = 1; w <= 4; w++) begin
            send(8'(w), 1'b1);
            wait_ack(1'b0);
        end
        chk("stream_ack_end", {31'b0, ack_tgl}, 32'd0);
        tick(2);

        // Sender flips twice while the first word is held
        out_ready = 1'b0;
        send(8'h11, 1'b1);
        wait_valid();
        req_data = 8'h22; req_tgl = ~req_tgl;
        tick(4);
        req_data = 8'h33; req_tgl = ~req_tgl;
        tick(4);
        chk("ovr_data_held", {24'b0, out_data}, 32'h11);
`ifdef TOGGLE_HS_RX_OVERRUN_EN
        chk("ovr_set", {31'b0, overrun}, 32'd1);
`endif
        out_ready = 1'b1;
        wait_ack(1'b0);
        tick(3);
        chk("ovr_no_extra", {31'b0, out_valid}, 32'd0);
`ifdef TOGGLE_HS_RX_OVERRUN_EN
        chk("ovr_sticky", {31'b0, overrun}, 32'd1);
`endif

        // Randomized words with random gaps and random back-pressure
        for (int w = 0; w < 24; w++) begin
            tick($urandom_range(0, 3));
            send(8'($urandom_range(0, 255)), 1'b1);
            wait_ack(1'b1);
        end
        out_ready = 1'b1;
        tick(2);

        // Reset while a word is held
        if (req_tgl) begin
            send(8'h77, 1'b1);
            wait_ack(1'b0);
        end
        out_ready = 1'b0;
        send(8'h99, 1'b1);
        wait_valid();
        tick(2);
        #2 reset = 1'b0;
        #1;
        chk("mrst_valid", {31'b0, out_valid}, 32'd0);
        chk("mrst_ack", {31'b0, ack_tgl}, 32'd0);
        exp_q.delete();
        exp_ack  = 1'b0;
        exp_rise = -1;
        req_data = 8'h5C;
        tick(2);
        reset = 1'b1;
        exp_q.push_back(8'h5C);
        exp_rise = cyc + 3;
        out_ready = 1'b1;
        wait_ack(1'b0);
        chk("mrst_recapture_ack", {31'b0, ack_tgl}, 32'd1);
        tick(3);

        chk("queue_drained", exp_q.size(), 32'd0);
        chk("latency_checked", exp_rise, 32'hFFFF_FFFF);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
